sprite_linebuf_banked: RTL and testbench

Parametrised double-buffered sprite line buffer sitting between the sprite renderer and the layer composer. One buffer is rendered into while the other is read out by the composer and then erased. The buffer is split into 2^BANK_BITS interleaved banks so an erase clears one full bank row per cycle. Beyond a plain line buffer, it adds an internal buffer-swap register, a bank-row erase engine with a busy flag that yields to renderer writes, and read-data selection aligned to the issuing cycle.

---
 rtl/sprite_linebuf_banked.sv | 155 +++++++++++++++
 tb/tb_sprite_linebuf_banked.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_linebuf_banked.sv
// Double-buffered, bank-interleaved sprite line buffer with a bank-row erase engine.
// The renderer owns one buffer and the composer owns the other; buffer_swap exchanges them.
// An erase clears one row across every bank per cycle and yields to renderer writes.

// One bank: simple dual-port RAM (one write, one registered read).
module sprite_linebuf_bank_ram #(
    parameter int DW = 16,
    parameter int RW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [RW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**RW];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port (read-before-write on a same-address collision).
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module sprite_linebuf_banked #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    BANK_BITS   = 2,
    parameter int                    ERASE_ROWS  = 160,
    parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buffer_swap,
    output logic                  active_render_buffer,
    input  logic [ADDR_WIDTH-1:0] renderer_rd_idx,
    output logic [DATA_WIDTH-1:0] renderer_rd_data,
    input  logic [ADDR_WIDTH-1:0] renderer_wr_idx,
    input  logic [DATA_WIDTH-1:0] renderer_wr_data,
    input  logic                  renderer_wr_en,
    input  logic [ADDR_WIDTH-1:0] composer_rd_idx,
    output logic [DATA_WIDTH-1:0] composer_rd_data,
    input  logic                  erase_start,
    output logic                  erase_busy
);
    localparam int NB = 2**BANK_BITS;
    localparam int RW = ADDR_WIDTH - BANK_BITS;
    localparam logic [RW-1:0] LAST_ROW = RW'(ERASE_ROWS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ERASE = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic                ebuf_q, ebuf_d;
    logic                active_q;
    logic                r_buf_q, c_buf_q;
    logic [BANK_BITS-1:0] r_bank_q, c_bank_q;

    logic                stall;
    logic                erase_we;

    logic [BANK_BITS-1:0] wr_bank;
    logic [RW-1:0]        wr_row, rr_row, cr_row;

    logic [1:0][NB-1:0][DATA_WIDTH-1:0] rdata_w;

    assign wr_bank = renderer_wr_idx[BANK_BITS-1:0];
    assign wr_row  = renderer_wr_idx[ADDR_WIDTH-1:BANK_BITS];
    assign rr_row  = renderer_rd_idx[ADDR_WIDTH-1:BANK_BITS];
    assign cr_row  = composer_rd_idx[ADDR_WIDTH-1:BANK_BITS];

    // A renderer write into the buffer being erased takes the write port; the erase holds its row.
    assign stall    = (state_q == ST_ERASE) && (ebuf_q == active_q) && renderer_wr_en;
    // Suppressed during reset so a reset mid-erase leaves the current row intact.
    assign erase_we = (state_q == ST_ERASE) && !stall && !rst;

    // Erase engine next state: start/restart latches the pre-swap composer buffer.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        ebuf_d  = ebuf_q;
        if (erase_start) begin
            state_d = ST_ERASE;
            row_d   = '0;
            ebuf_d  = ~active_q;
        end else if (state_q == ST_ERASE && !stall) begin
            if (row_q == LAST_ROW) state_d = ST_IDLE;
            else                   row_d   = row_q + 1'b1;
        end
    end

    // Control state: erase engine, buffer ownership and read-issue selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            ebuf_q   <= 1'b0;
            active_q <= 1'b0;
            r_buf_q  <= 1'b0;
            c_buf_q  <= 1'b0;
            r_bank_q <= '0;
            c_bank_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            ebuf_q   <= ebuf_d;
            active_q <= active_q ^ buffer_swap;
            r_buf_q  <= active_q;
            c_buf_q  <= ~active_q;
            r_bank_q <= renderer_rd_idx[BANK_BITS-1:0];
            c_bank_q <= composer_rd_idx[BANK_BITS-1:0];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar k = 0; k < NB; k++) begin : g_bank
            localparam logic                 BUF  = 1'(b);
            localparam logic [BANK_BITS-1:0] BANK = BANK_BITS'(k);

            logic                  ren_we, era_we;
            logic [RW-1:0]         waddr, raddr;
            logic [DATA_WIDTH-1:0] wdata;

            assign ren_we = renderer_wr_en && (active_q == BUF) && (wr_bank == BANK);
            assign era_we = erase_we && (ebuf_q == BUF);
            assign waddr  = ren_we ? wr_row : row_q;
            assign wdata  = ren_we ? renderer_wr_data : ERASE_VALUE;
            // Each buffer has exactly one reader at a time, picked by ownership.
            assign raddr  = (active_q == BUF) ? rr_row : cr_row;

            sprite_linebuf_bank_ram #(
                .DW (DATA_WIDTH),
                .RW (RW)
            ) u_ram (
                .clk_i   (clk),
                .we_i    (ren_we | era_we),
                .waddr_i (waddr),
                .wdata_i (wdata),
                .raddr_i (raddr),
                .rdata_o (rdata_w[b][k])
            );
        end
    end

    // Output muxes use selects captured at read issue, so a swap cannot disturb in-flight data.
    assign renderer_rd_data     = rdata_w[r_buf_q][r_bank_q];
    assign composer_rd_data     = rdata_w[c_buf_q][c_bank_q];
    assign active_render_buffer = active_q;
    assign erase_busy           = (state_q == ST_ERASE);
endmodule

// File: tb/tb_sprite_linebuf_banked.sv
// Scoreboard bench: expected read data queued at issue, popped one cycle later.
module tb_sprite_linebuf_banked;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic        swap, es, wen;
    logic [9:0]  widx, ridx, cidx;
    logic [15:0] wdata;
    logic        arb, busy;
    logic [15:0] rdat, cdat;
    // 8-bank instance
    logic        swap8, es8, wen8;
    logic [10:0] widx8, ridx8, cidx8;
    logic [15:0] wdata8;
    logic        arb8, busy8;
    logic [15:0] rdat8, cdat8;

    sprite_linebuf_banked dut (
        .clk(clk), .rst(rst), .buffer_swap(swap), .active_render_buffer(arb),
        .renderer_rd_idx(ridx), .renderer_rd_data(rdat),
        .renderer_wr_idx(widx), .renderer_wr_data(wdata), .renderer_wr_en(wen),
        .composer_rd_idx(cidx), .composer_rd_data(cdat),
        .erase_start(es), .erase_busy(busy)
    );

    sprite_linebuf_banked #(.ADDR_WIDTH(11), .BANK_BITS(3), .ERASE_ROWS(256)) dut8 (
        .clk(clk), .rst(rst), .buffer_swap(swap8), .active_render_buffer(arb8),
        .renderer_rd_idx(ridx8), .renderer_rd_data(rdat8),
        .renderer_wr_idx(widx8), .renderer_wr_data(wdata8), .renderer_wr_en(wen8),
        .composer_rd_idx(cidx8), .composer_rd_data(cdat8),
        .erase_start(es8), .erase_busy(busy8)
    );

    int n_vec = 0, n_err = 0;
    int cnt;

    // streams: 0 dut renderer, 1 dut composer, 2 dut8 renderer, 3 dut8 composer
    logic [3:0]  iss, due;
    logic [15:0] q0[$], q1[$], q2[$], q3[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) due <= iss;

    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (due[s]) begin
                logic [15:0] e, g;
                int sz;
                case (s)
                    0: begin sz = q0.size(); g = rdat;  end
                    1: begin sz = q1.size(); g = cdat;  end
                    2: begin sz = q2.size(); g = rdat8; end
                    default: begin sz = q3.size(); g = cdat8; end
                endcase
                if (sz == 0) chk("sb_underflow", 32'(s), 32'hFFFF);
                else begin
                    case (s)
                        0: e = q0.pop_front();
                        1: e = q1.pop_front();
                        2: e = q2.pop_front();
                        default: e = q3.pop_front();
                    endcase
                    case (s)
                        0: chk("r_rd", 32'(g), 32'(e));
                        1: chk("c_rd", 32'(g), 32'(e));
                        2: chk("r_rd8", 32'(g), 32'(e));
                        default: chk("c_rd8", 32'(g), 32'(e));
                    endcase
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        iss = '0; swap = 0; es = 0; wen = 0; swap8 = 0; es8 = 0; wen8 = 0;
    endtask

    task automatic rd(input int s, input int idx, input logic [15:0] e);
        case (s)
            0: begin ridx  = idx[9:0];  q0.push_back(e); end
            1: begin cidx  = idx[9:0];  q1.push_back(e); end
            2: begin ridx8 = idx[10:0]; q2.push_back(e); end
            default: begin cidx8 = idx[10:0]; q3.push_back(e); end
        endcase
        iss[s] = 1'b1;
    endtask

    task automatic fill(input logic [15:0] x);
        for (int i = 0; i < 640; i++) begin
            wen = 1; widx = i[9:0]; wdata = 16'(i) ^ x; tick;
        end
    endtask

    task automatic fill8(input logic [15:0] x);
        for (int i = 0; i < 2048; i++) begin
            wen8 = 1; widx8 = i[10:0]; wdata8 = 16'(i) ^ x; tick;
        end
    endtask

    initial begin
        iss = '0; swap = 0; es = 0; wen = 0; widx = '0; ridx = '0; cidx = '0; wdata = '0;
        swap8 = 0; es8 = 0; wen8 = 0; widx8 = '0; ridx8 = '0; cidx8 = '0; wdata8 = '0;
        rst = 1;
        tick; tick;
        rst = 0;
        chk("rst_arb", 32'(arb), 0);   chk("rst_busy", 32'(busy), 0);
        chk("rst_arb8", 32'(arb8), 0); chk("rst_busy8", 32'(busy8), 0);

        // single write then read-back
        wen = 1; widx = 10'd5; wdata = 16'h1234; tick;
        rd(0, 5, 16'h1234); tick; tick;

        // fill buffer 0, swap, composer streams it back
        fill(16'h0000);
        swap = 1; tick;
        chk("swap_arb", 32'(arb), 1);
        for (int i = 0; i < 640; i++) begin rd(1, i, 16'(i)); tick; end

        // plain erase of buffer 0
        es = 1; tick;
        cnt = 0;
        while (busy && cnt < 1000) begin cnt++; tick; end
        chk("erase_len", 32'(cnt), 160);
        for (int i = 0; i < 640; i++) begin rd(1, i, 16'h0); tick; end

        // erase buffer 1, swap 50 cycles in, 10 renderer writes stall it
        fill(16'h0100);
        swap = 1; tick;
        es = 1; tick;
        cnt = 0;
        while (busy && cnt < 1000) begin
            if (cnt == 50) swap = 1;
            if (cnt >= 52 && cnt < 72 && (cnt % 2) == 0) begin
                wen = 1; widx = 10'((cnt - 52) / 2); wdata = 16'hA000 + 16'((cnt - 52) / 2);
            end
            cnt++; tick;
        end
        chk("stall_len", 32'(cnt), 170);
        swap = 1; tick;
        chk("arb_back", 32'(arb), 0);
        for (int i = 0; i < 640; i++) begin
            rd(1, i, (i < 10) ? 16'hA000 + 16'(i) : 16'h0); tick;
        end
        // read in flight across a swap comes from the issuing-cycle buffer
        rd(1, 3, 16'hA003); swap = 1; tick; tick;

        // simultaneous erase_start and swap erase the pre-swap composer buffer
        fill(16'h5555);
        swap = 1; tick;
        fill(16'h3333);
        es = 1; swap = 1; tick;
        cnt = 0;
        while (busy && cnt < 1000) begin cnt++; tick; end
        chk("erase_len2", 32'(cnt), 160);
        for (int i = 0; i < 640; i++) begin rd(1, i, 16'(i) ^ 16'h3333); tick; end
        swap = 1; tick;
        for (int i = 0; i < 640; i++) begin rd(1, i, 16'h0); tick; end
        rd(0, 7, 16'd7 ^ 16'h3333); tick;

        // 8-bank instance: full erase
        fill8(16'h7777);
        swap8 = 1; tick;
        es8 = 1; tick;
        cnt = 0;
        while (busy8 && cnt < 1000) begin cnt++; tick; end
        chk("erase_len8", 32'(cnt), 256);
        for (int i = 0; i < 2048; i++) begin rd(3, i, 16'h0); tick; end

        // reset 100 cycles into an erase
        fill8(16'h1111);
        swap8 = 1; tick;
        es8 = 1; tick;
        cnt = 0;
        while (busy8 && cnt < 100) begin cnt++; tick; end
        chk("pre_rst_busy8", 32'(busy8), 1);
        rst = 1; tick; rst = 0;
        chk("mid_rst_busy8", 32'(busy8), 0);
        chk("mid_rst_arb8", 32'(arb8), 0);
        for (int i = 0; i < 2048; i++) begin
            rd(3, i, (i < 800) ? 16'h0 : 16'(i) ^ 16'h1111); tick;
        end
        rd(2, 9, 16'h0); tick;

        tick; tick;
        chk("drain", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
